// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// master drives start and operands; slave returns busy, done and the result.
interface serial_subtractor_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] minuend;
  logic [N-1:0] subtrahend;
  logic         busy;
  logic         done;
  logic [N-1:0] difference;
  logic         borrow_out;
  logic         overflow;

  modport master (
    output start, minuend, subtrahend,
    input  busy, done, difference, borrow_out, overflow
  );

  modport slave (
    input  start, minuend, subtrahend,
    output busy, done, difference, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle A-B, W bits per cycle LSB first, borrow held between chunks.
// Ports: clk, rst_n (async low), bus (slave: start/operands in, busy/done/result out).
module serial_subtractor #(
  parameter int N = 32,
  parameter int W = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int C  = N / W;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad_param
    $error("serial_subtractor: W must divide N and 1 <= W <= N");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]  a_q, b_q, res_q, res_nx;
  logic [N-1:0]  diff_q;
  logic          brw_q, bo_q, ov_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    sub;
  logic          accept, last, ovf;

  assign accept = bus.start && (state != BUSY);
  assign last   = (cnt_q == CW'(C - 1));

  // One W-bit chunk plus incoming borrow; sub[W] is the outgoing borrow.
  always_comb begin
    sub = {1'b0, a_q[int'(cnt_q)*W +: W]}
        - {1'b0, b_q[int'(cnt_q)*W +: W]}
        - (W+1)'(brw_q);
    res_nx = res_q;
    res_nx[int'(cnt_q)*W +: W] = sub[W-1:0];
    ovf = (a_q[N-1] ^ b_q[N-1])
        & (res_nx[N-1] ^ a_q[N-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): if (bus.start) state_nx = BUSY;
      (state == BUSY): if (last) state_nx = DONE;
      (state == DONE): state_nx = bus.start ? BUSY : IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state == BUSY);
    bus.done       = (state == DONE);
    bus.difference = diff_q;
    bus.borrow_out = bo_q;
    bus.overflow   = ov_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.minuend;
      b_q   <= bus.subtrahend;
      brw_q <= 1'b0;
      cnt_q <= '0;
    end else if (state == BUSY) begin
      res_q <= res_nx;
      brw_q <= sub[W];
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        diff_q <= res_nx;
        bo_q   <= sub[W];
        ov_q   <= ovf;
      end
    end
  end
endmodule
